// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared ALU codes, operand-select encodings and bubble values
package pipeline_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_ADDU = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_SUBU = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_LUI  = 4'd11,
        ALU_SLTU = 4'd12,
        ALU_SLT  = 4'd13,
        ALU_COP0 = 4'd14
    } alu_op_e;

    localparam logic [1:0] ALU_SRC_RT   = 2'd0;
    localparam logic [1:0] ALU_SRC_SEXT = 2'd1;
    localparam logic [1:0] ALU_SRC_ZEXT = 2'd2;

    localparam int unsigned REG_ZERO = 0;

    localparam logic       BUBBLE_VALID  = 1'b0;
    localparam logic       BUBBLE_CTRL   = 1'b0;
    localparam logic [3:0] BUBBLE_ALU_OP = ALU_ADD;

endpackage

// File: rtl/operand_forward.sv
// rtl/operand_forward.sv - combinational EX/MEM > MEM/WB > register-data operand select
module operand_forward
    import pipeline_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int RADDR = 5
) (
    input  logic [RADDR-1:0] addr,
    input  logic [XLEN-1:0]  reg_data,
    input  logic             exmem_reg_write,
    input  logic [RADDR-1:0] exmem_dest,
    input  logic [XLEN-1:0]  exmem_result,
    input  logic             memwb_reg_write,
    input  logic [RADDR-1:0] memwb_dest,
    input  logic [XLEN-1:0]  memwb_result,
    output logic [XLEN-1:0]  value
);

    logic addr_nonzero;

    assign addr_nonzero = (addr != RADDR'(REG_ZERO));

    always_comb begin
        value = reg_data;
        if (addr_nonzero && exmem_reg_write && exmem_dest == addr) begin
            value = exmem_result;
        end else if (addr_nonzero && memwb_reg_write && memwb_dest == addr) begin
            value = memwb_result;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with operand forwarding and load-use detection
module id_ex_stage
    import pipeline_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int RADDR = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [RADDR-1:0] id_rs_addr,
    input  logic [RADDR-1:0] id_rt_addr,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [XLEN-1:0]  id_rs_data,
    input  logic [XLEN-1:0]  id_rt_data,
    input  logic [RADDR-1:0] id_dest,
    input  logic [15:0]      id_imm,
    input  logic [4:0]       id_shamt,
    input  logic [3:0]       id_alu_op,
    input  logic [1:0]       id_alu_src,
    input  logic             id_shift_imm,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             exmem_reg_write,
    input  logic [RADDR-1:0] exmem_dest,
    input  logic [XLEN-1:0]  exmem_result,
    input  logic             memwb_reg_write,
    input  logic [RADDR-1:0] memwb_dest,
    input  logic [XLEN-1:0]  memwb_result,
    output logic [XLEN-1:0]  ex_alu_a,
    output logic [XLEN-1:0]  ex_alu_b,
    output logic [3:0]       ex_alu_op,
    output logic [XLEN-1:0]  ex_store_data,
    output logic [RADDR-1:0] ex_dest,
    output logic [XLEN-1:0]  ex_pc,
    output logic             ex_valid,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             load_use_hazard
);

    logic             valid_q, valid_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [RADDR-1:0] rs_addr_q, rs_addr_d;
    logic [RADDR-1:0] rt_addr_q, rt_addr_d;
    logic [XLEN-1:0]  rs_data_q, rs_data_d;
    logic [XLEN-1:0]  rt_data_q, rt_data_d;
    logic [RADDR-1:0] dest_q, dest_d;
    logic [15:0]      imm_q, imm_d;
    logic [4:0]       shamt_q, shamt_d;
    logic [3:0]       alu_op_q, alu_op_d;
    logic [1:0]       alu_src_q, alu_src_d;
    logic             shift_imm_q, shift_imm_d;
    logic             reg_write_q, reg_write_d;
    logic             mem_read_q, mem_read_d;
    logic             mem_write_q, mem_write_d;

    logic [XLEN-1:0]  fwd_rs, fwd_rt;
    logic             rs_match, rt_match;
    logic             wt_rs, wt_rt;

    // A load still in EX cannot supply its data until MEM, so a dependent ID instruction waits.
    assign rs_match = id_uses_rs && (id_rs_addr == dest_q);
    assign rt_match = id_uses_rt && (id_rt_addr == dest_q);
    assign load_use_hazard = valid_q && mem_read_q && (dest_q != RADDR'(REG_ZERO))
                             && (rs_match || rt_match) && id_valid;

    // The register file does not bypass its own write port, so catch the WB write on capture.
    assign wt_rs = memwb_reg_write && (memwb_dest != RADDR'(REG_ZERO)) && (memwb_dest == id_rs_addr);
    assign wt_rt = memwb_reg_write && (memwb_dest != RADDR'(REG_ZERO)) && (memwb_dest == id_rt_addr);

    always_comb begin
        valid_d     = valid_q;
        pc_d        = pc_q;
        rs_addr_d   = rs_addr_q;
        rt_addr_d   = rt_addr_q;
        rs_data_d   = rs_data_q;
        rt_data_d   = rt_data_q;
        dest_d      = dest_q;
        imm_d       = imm_q;
        shamt_d     = shamt_q;
        alu_op_d    = alu_op_q;
        alu_src_d   = alu_src_q;
        shift_imm_d = shift_imm_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        if (flush || load_use_hazard) begin
            valid_d     = BUBBLE_VALID;
            pc_d        = '0;
            rs_addr_d   = RADDR'(REG_ZERO);
            rt_addr_d   = RADDR'(REG_ZERO);
            rs_data_d   = '0;
            rt_data_d   = '0;
            dest_d      = RADDR'(REG_ZERO);
            imm_d       = '0;
            shamt_d     = '0;
            alu_op_d    = BUBBLE_ALU_OP;
            alu_src_d   = ALU_SRC_RT;
            shift_imm_d = BUBBLE_CTRL;
            reg_write_d = BUBBLE_CTRL;
            mem_read_d  = BUBBLE_CTRL;
            mem_write_d = BUBBLE_CTRL;
        end else if (!stall) begin
            valid_d     = id_valid;
            pc_d        = id_pc;
            rs_addr_d   = id_rs_addr;
            rt_addr_d   = id_rt_addr;
            rs_data_d   = wt_rs ? memwb_result : id_rs_data;
            rt_data_d   = wt_rt ? memwb_result : id_rt_data;
            dest_d      = id_dest;
            imm_d       = id_imm;
            shamt_d     = id_shamt;
            alu_op_d    = id_alu_op;
            alu_src_d   = id_alu_src;
            shift_imm_d = id_shift_imm;
            reg_write_d = id_reg_write;
            mem_read_d  = id_mem_read;
            mem_write_d = id_mem_write;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= BUBBLE_VALID;
            pc_q        <= '0;
            rs_addr_q   <= RADDR'(REG_ZERO);
            rt_addr_q   <= RADDR'(REG_ZERO);
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            dest_q      <= RADDR'(REG_ZERO);
            imm_q       <= '0;
            shamt_q     <= '0;
            alu_op_q    <= BUBBLE_ALU_OP;
            alu_src_q   <= ALU_SRC_RT;
            shift_imm_q <= BUBBLE_CTRL;
            reg_write_q <= BUBBLE_CTRL;
            mem_read_q  <= BUBBLE_CTRL;
            mem_write_q <= BUBBLE_CTRL;
        end else begin
            valid_q     <= valid_d;
            pc_q        <= pc_d;
            rs_addr_q   <= rs_addr_d;
            rt_addr_q   <= rt_addr_d;
            rs_data_q   <= rs_data_d;
            rt_data_q   <= rt_data_d;
            dest_q      <= dest_d;
            imm_q       <= imm_d;
            shamt_q     <= shamt_d;
            alu_op_q    <= alu_op_d;
            alu_src_q   <= alu_src_d;
            shift_imm_q <= shift_imm_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
        end
    end

    operand_forward #(.XLEN(XLEN), .RADDR(RADDR)) u_fwd_rs (
        .addr            (rs_addr_q),
        .reg_data        (rs_data_q),
        .exmem_reg_write (exmem_reg_write),
        .exmem_dest      (exmem_dest),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_dest      (memwb_dest),
        .memwb_result    (memwb_result),
        .value           (fwd_rs)
    );

    operand_forward #(.XLEN(XLEN), .RADDR(RADDR)) u_fwd_rt (
        .addr            (rt_addr_q),
        .reg_data        (rt_data_q),
        .exmem_reg_write (exmem_reg_write),
        .exmem_dest      (exmem_dest),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_dest      (memwb_dest),
        .memwb_result    (memwb_result),
        .value           (fwd_rt)
    );

    always_comb begin
        ex_alu_a = shift_imm_q ? {{(XLEN-5){1'b0}}, shamt_q} : fwd_rs;
        case (alu_src_q)
            ALU_SRC_SEXT: ex_alu_b = {{(XLEN-16){imm_q[15]}}, imm_q};
            ALU_SRC_ZEXT: ex_alu_b = {{(XLEN-16){1'b0}}, imm_q};
            default:      ex_alu_b = fwd_rt;
        endcase
    end

    assign ex_alu_op     = alu_op_q;
    assign ex_store_data = fwd_rt;
    assign ex_dest       = dest_q;
    assign ex_pc         = pc_q;
    assign ex_valid      = valid_q;
    assign ex_reg_write  = reg_write_q;
    assign ex_mem_read   = mem_read_q;
    assign ex_mem_write  = mem_write_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - self-checking bench for id_ex_stage
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall, flush, id_valid;
    logic [31:0] id_pc, id_rs_data, id_rt_data;
    logic [4:0]  id_rs_addr, id_rt_addr, id_dest, id_shamt;
    logic        id_uses_rs, id_uses_rt;
    logic [15:0] id_imm;
    logic [3:0]  id_alu_op;
    logic [1:0]  id_alu_src;
    logic        id_shift_imm, id_reg_write, id_mem_read, id_mem_write;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_dest, memwb_dest;
    logic [31:0] exmem_result, memwb_result;
    logic [31:0] ex_alu_a, ex_alu_b, ex_store_data, ex_pc;
    logic [3:0]  ex_alu_op;
    logic [4:0]  ex_dest;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, load_use_hazard;

    int n_tests = 0;
    int n_fail  = 0;

    id_ex_stage #(.XLEN(32), .RADDR(5)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_pc(id_pc),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_dest(id_dest), .id_imm(id_imm), .id_shamt(id_shamt),
        .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .id_shift_imm(id_shift_imm),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .exmem_reg_write(exmem_reg_write), .exmem_dest(exmem_dest), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_dest(memwb_dest), .memwb_result(memwb_result),
        .ex_alu_a(ex_alu_a), .ex_alu_b(ex_alu_b), .ex_alu_op(ex_alu_op),
        .ex_store_data(ex_store_data), .ex_dest(ex_dest), .ex_pc(ex_pc),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .load_use_hazard(load_use_hazard)
    );

    always #5 clk = ~clk;

    // Model of the instruction currently sitting in EX.
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs, rt;
        logic [31:0] rsd, rtd;
        logic [4:0]  dest;
        logic [15:0] imm;
        logic [4:0]  shamt;
        logic [3:0]  op;
        logic [1:0]  src;
        logic        shimm, rw, mr, mw;
    } ent_t;

    ent_t m = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] v);
        if (a == 5'd0) return v;
        if (exmem_reg_write && exmem_dest == a) return exmem_result;
        if (memwb_reg_write && memwb_dest == a) return memwb_result;
        return v;
    endfunction

    function automatic logic [31:0] wb_through(input logic [4:0] a, input logic [31:0] v);
        if (a != 5'd0 && memwb_reg_write && memwb_dest == a) return memwb_result;
        return v;
    endfunction

    function automatic logic exp_hazard();
        logic dep;
        dep = (id_uses_rs && id_rs_addr == m.dest) || (id_uses_rt && id_rt_addr == m.dest);
        return id_valid && m.valid && m.mr && (m.dest != 5'd0) && dep;
    endfunction

    function automatic logic [31:0] exp_a();
        if (m.shimm) return {27'd0, m.shamt};
        return fwd(m.rs, m.rsd);
    endfunction

    function automatic logic [31:0] exp_b();
        if (m.src == 2'd1) return {{16{m.imm[15]}}, m.imm};
        if (m.src == 2'd2) return {16'd0, m.imm};
        return fwd(m.rt, m.rtd);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m = '0;
        end else if (flush || exp_hazard()) begin
            m = '0;
        end else if (!stall) begin
            m.valid = id_valid;   m.pc = id_pc;
            m.rs = id_rs_addr;    m.rt = id_rt_addr;
            m.rsd = wb_through(id_rs_addr, id_rs_data);
            m.rtd = wb_through(id_rt_addr, id_rt_data);
            m.dest = id_dest;     m.imm = id_imm;     m.shamt = id_shamt;
            m.op = id_alu_op;     m.src = id_alu_src; m.shimm = id_shift_imm;
            m.rw = id_reg_write;  m.mr = id_mem_read; m.mw = id_mem_write;
        end
    end

    always @(negedge clk) begin
        check("alu_a",       ex_alu_a,               exp_a());
        check("alu_b",       ex_alu_b,               exp_b());
        check("alu_op",      {28'd0, ex_alu_op},     {28'd0, m.op});
        check("store_data",  ex_store_data,          fwd(m.rt, m.rtd));
        check("dest",        {27'd0, ex_dest},       {27'd0, m.dest});
        check("pc",          ex_pc,                  m.pc);
        check("ctrl",        {28'd0, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write},
                             {28'd0, m.valid, m.rw, m.mr, m.mw});
        check("hazard",      {31'd0, load_use_hazard}, {31'd0, exp_hazard()});
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_id();
        id_valid = 0; id_pc = 0; id_rs_addr = 0; id_rt_addr = 0;
        id_uses_rs = 0; id_uses_rt = 0; id_rs_data = 0; id_rt_data = 0;
        id_dest = 0; id_imm = 0; id_shamt = 0; id_alu_op = 0; id_alu_src = 0;
        id_shift_imm = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
    endtask

    task automatic clear_fwd();
        exmem_reg_write = 0; exmem_dest = 0; exmem_result = 0;
        memwb_reg_write = 0; memwb_dest = 0; memwb_result = 0;
    endtask

    initial begin
        stall = 0; flush = 0;
        clear_id();
        clear_fwd();
        cyc(); cyc();
        check("rst_valid", {31'd0, ex_valid}, 32'd0);
        check("rst_op",    {28'd0, ex_alu_op}, 32'd0);
        rst = 0;

        // add $3,$1,$2
        id_valid = 1; id_pc = 32'h100; id_rs_addr = 1; id_rs_data = 32'h100;
        id_rt_addr = 2; id_rt_data = 32'h200; id_uses_rs = 1; id_uses_rt = 1;
        id_dest = 3; id_alu_op = 4'd0; id_reg_write = 1;
        cyc();
        check("add_a", ex_alu_a, 32'h100);
        check("add_b", ex_alu_b, 32'h200);

        // sub $4,$3,$5 with both later stages writing $3
        id_pc = 32'h104; id_rs_addr = 3; id_rs_data = 32'hdead; id_rt_addr = 5;
        id_rt_data = 32'h7; id_dest = 4; id_alu_op = 4'd2;
        exmem_reg_write = 1; exmem_dest = 3; exmem_result = 32'h10;
        memwb_reg_write = 1; memwb_dest = 3; memwb_result = 32'h20;
        cyc();
        check("sub_exmem_prio", ex_alu_a, 32'h10);
        check("sub_b", ex_alu_b, 32'h7);
        check("sub_op", {28'd0, ex_alu_op}, 32'd2);
        exmem_reg_write = 0;
        #1 check("sub_memwb", ex_alu_a, 32'h20);
        memwb_reg_write = 0;
        #1 check("sub_writethrough", ex_alu_a, 32'h20);

        // lw $2, 4($1) followed by dependent add $6,$2,$7
        clear_id();
        id_valid = 1; id_pc = 32'h108; id_rs_addr = 1; id_rs_data = 32'h1000; id_uses_rs = 1;
        id_dest = 2; id_mem_read = 1; id_reg_write = 1; id_alu_src = 2'd1; id_imm = 16'd4;
        cyc();
        check("lw_b", ex_alu_b, 32'd4);
        clear_id();
        id_valid = 1; id_pc = 32'h10c; id_rs_addr = 2; id_rt_addr = 7; id_rt_data = 32'h70;
        id_uses_rs = 1; id_uses_rt = 1; id_dest = 6; id_reg_write = 1;
        #1 check("lu_hazard", {31'd0, load_use_hazard}, 32'd1);
        cyc();
        check("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
        check("lu_bubble_rw", {31'd0, ex_reg_write}, 32'd0);
        check("lu_cleared", {31'd0, load_use_hazard}, 32'd0);
        exmem_reg_write = 1; exmem_dest = 2; exmem_result = 32'hab;
        cyc();
        check("lu_resume_dest", {27'd0, ex_dest}, 32'd6);
        check("lu_resume_a", ex_alu_a, 32'hab);
        clear_fwd();

        // immediates: sign, zero, reserved select
        clear_id();
        id_valid = 1; id_pc = 32'h110; id_rs_addr = 1; id_rs_data = 32'h5; id_rt_addr = 2;
        id_rt_data = 32'h33; id_dest = 8; id_reg_write = 1; id_alu_src = 2'd1; id_imm = 16'hfffe;
        cyc();
        check("addi_sext", ex_alu_b, 32'hfffffffe);
        id_alu_src = 2'd2; id_alu_op = 4'd5;
        cyc();
        check("ori_zext", ex_alu_b, 32'h0000fffe);
        id_alu_src = 2'd3;
        cyc();
        check("src3_rt", ex_alu_b, 32'h33);

        // sll $8,$2,4
        clear_id();
        id_valid = 1; id_rs_addr = 0; id_rs_data = 32'h999; id_rt_addr = 2; id_rt_data = 32'h1;
        id_shamt = 5'd4; id_shift_imm = 1; id_alu_op = 4'd8; id_dest = 8; id_reg_write = 1;
        cyc();
        check("sll_a", ex_alu_a, 32'd4);
        check("sll_b", ex_alu_b, 32'd1);

        // writes to $0 downstream must not forward
        clear_id();
        id_valid = 1; id_dest = 9; id_reg_write = 1;
        exmem_reg_write = 1; exmem_dest = 0; exmem_result = 32'h55;
        memwb_reg_write = 1; memwb_dest = 0; memwb_result = 32'h66;
        cyc();
        check("r0_a", ex_alu_a, 32'd0);
        check("r0_b", ex_alu_b, 32'd0);
        clear_fwd();

        // flush together with stall loads a bubble
        clear_id();
        id_valid = 1; id_pc = 32'h200; id_dest = 9; id_reg_write = 1;
        cyc();
        check("pre_flush_valid", {31'd0, ex_valid}, 32'd1);
        id_pc = 32'h204; id_dest = 10; flush = 1; stall = 1;
        cyc();
        check("flush_valid", {31'd0, ex_valid}, 32'd0);
        check("flush_dest", {27'd0, ex_dest}, 32'd0);
        check("flush_pc", ex_pc, 32'd0);
        flush = 0; stall = 0;

        // stall alone holds for three cycles, forwarding keeps tracking
        id_pc = 32'h208; id_dest = 11; id_rs_addr = 1; id_rs_data = 32'h11;
        cyc();
        check("pre_stall_pc", ex_pc, 32'h208);
        stall = 1; id_pc = 32'h20c; id_dest = 12; id_rs_data = 32'h22;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("stall_pc", ex_pc, 32'h208);
            check("stall_dest", {27'd0, ex_dest}, 32'd11);
        end
        exmem_reg_write = 1; exmem_dest = 1; exmem_result = 32'h77;
        #1 check("stall_fwd", ex_alu_a, 32'h77);
        clear_fwd();
        stall = 0;
        cyc();
        check("release_pc", ex_pc, 32'h20c);
        check("release_a", ex_alu_a, 32'h22);

        // asynchronous reset while a valid entry is in EX
        @(posedge clk);
        #2 rst = 1;
        #1;
        check("async_valid", {31'd0, ex_valid}, 32'd0);
        check("async_pc", ex_pc, 32'd0);
        check("async_a", ex_alu_a, 32'd0);
        check("async_op", {28'd0, ex_alu_op}, 32'd0);
        cyc();
        rst = 0;
        clear_id();
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
